// File: rtl/nibble_serial_adder.sv
// Nibble-serial operand sequencer around an external combinational 4-bit full adder.
// Adds two 4*NIBBLES-bit operands LSB nibble first, one nibble per clock.
module nibble_serial_adder #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
   output logic [3:0]           fa_a,
   output logic [3:0]           fa_b,
   output logic                 fa_cin,
   input  logic [3:0]           fa_sum,
   input  logic                 fa_cout,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout
);

   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q;
   logic [W-1:0]    a_q, b_q, work_q, work_next, sum_q;
   logic            cin_q, carry_q, cout_q, busy_q, done_q;
   logic [IdxW-1:0] idx_q;

   // Adder inputs are steered straight from the latched operands; nothing is registered here.
   always_comb begin
      fa_a      = 4'd0;
      fa_b      = 4'd0;
      fa_cin    = 1'b0;
      work_next = work_q;
      if (state_q == StRun) begin
         fa_a   = a_q[4*int'(idx_q) +: 4];
         fa_b   = b_q[4*int'(idx_q) +: 4];
         fa_cin = (idx_q == '0) ? cin_q : carry_q;
         work_next[4*int'(idx_q) +: 4] = fa_sum;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  cin_q   <= cin;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               work_q  <= work_next;
               carry_q <= fa_cout;
               if (idx_q == LastIdx) begin
                  // Final nibble lands directly in the visible result together with its carry.
                  sum_q   <= work_next;
                  cout_q  <= fa_cout;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  idx_q <= idx_q + IdxW'(1);
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: a 4-nibble instance with directed and random operations,
// and a 1-nibble instance swept exhaustively; both wrapped by a behavioural adder.
module tb_nibble_serial_adder;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst, start, cin;
   logic [15:0] a, b, sum;
   logic [3:0]  fa_a, fa_b, fa_sum;
   logic        fa_cin, fa_cout, busy, done, cout;
   logic [4:0]  add4;

   logic        start1, cin1;
   logic [3:0]  a1, b1, sum1, fa_a1, fa_b1, fa_sum1;
   logic        fa_cin1, fa_cout1, busy1, done1, cout1;
   logic [4:0]  add1;

   int checks = 0;
   int errors = 0;
   logic [16:0] held;

   always #5 clk = ~clk;

   assign add4    = {1'b0, fa_a} + {1'b0, fa_b} + {4'd0, fa_cin};
   assign fa_sum  = add4[3:0];
   assign fa_cout = add4[4];
   assign add1    = {1'b0, fa_a1} + {1'b0, fa_b1} + {4'd0, fa_cin1};
   assign fa_sum1  = add1[3:0];
   assign fa_cout1 = add1[4];

   nibble_serial_adder #(.NIBBLES(N)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   nibble_serial_adder #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_sum(fa_sum1), .fa_cout(fa_cout1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Carry entering nibble k is bit 4k of the sum of the low 4k bits.
   function automatic logic carry_into(input logic [15:0] av, bv, input logic c, input int k);
      longint unsigned lo, m;
      if (k == 0) return c;
      m  = (64'd1 << (4 * k)) - 1;
      lo = (longint'(av) & m) + (longint'(bv) & m) + longint'(c);
      return lo[4*k];
   endfunction

   task automatic run4(input logic [15:0] av, bv, input logic c,
                       input int rst_at, input int restart_at);
      logic [16:0] total;
      logic [15:0] sh;
      total = {1'b0, av} + {1'b0, bv} + {16'd0, c};
      @(negedge clk);
      a = av; b = bv; cin = c; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < N; k++) begin
         check("run_busy", 64'(busy), 64'd1);
         check("run_done", 64'(done), 64'd0);
         sh = av >> (4 * k);
         check("fa_a", 64'(fa_a), 64'(sh[3:0]));
         sh = bv >> (4 * k);
         check("fa_b", 64'(fa_b), 64'(sh[3:0]));
         check("fa_cin", 64'(fa_cin), 64'(carry_into(av, bv, c, k)));
         check("run_hold", 64'({cout, sum}), 64'(held));
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
         start = (k == restart_at);
         if (k == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0; start = 1'b0;
            held = '0;
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_sum", 64'({cout, sum}), 64'd0);
            check("rst_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
            for (int j = 0; j < N + 2; j++) begin
               @(negedge clk);
               check("rst_nodone", 64'(done), 64'd0);
            end
            return;
         end
         @(negedge clk);
      end
      start = 1'b0;
      held = total;
      check("done_pulse", 64'(done), 64'd1);
      check("done_busy", 64'(busy), 64'd0);
      check("result", 64'({cout, sum}), 64'(total));
      check("done_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
      @(negedge clk);
      check("done_drop", 64'(done), 64'd0);
      check("idle_hold", 64'({cout, sum}), 64'(held));
      check("idle_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
      @(negedge clk);
      check("no_restart", 64'(busy), 64'd0);
   endtask

   task automatic run1(input logic [3:0] av, bv, input logic c);
      @(negedge clk);
      a1 = av; b1 = bv; cin1 = c; start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      check("n1_busy", 64'({busy1, done1, fa_cin1}), 64'({2'b10, c}));
      @(negedge clk);
      check("n1_sum", 64'({done1, cout1, sum1}),
            64'({1'b1, 5'({1'b0, av} + {1'b0, bv} + {4'd0, c})}));
      @(negedge clk);
      check("n1_drop", 64'(done1), 64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      held = '0;
      repeat (2) @(negedge clk);
      check("reset_out", 64'({busy, done, cout, sum}), 64'd0);
      check("reset_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
      check("reset_n1", 64'({busy1, done1, cout1, sum1}), 64'd0);
      rst = 1'b0;

      run4(16'h0000, 16'h0000, 1'b0, -1, -1);
      run4(16'hFFFF, 16'h0001, 1'b0, -1, -1);
      run4(16'h1234, 16'h4321, 1'b1, -1, -1);
      run4(16'h00FF, 16'h0001, 1'b0, -1, 1);
      run4(16'hAAAA, 16'h5555, 1'b0, 1, -1);
      run4(16'h1234, 16'h4321, 1'b1, -1, -1);
      run4(16'hFFFF, 16'hFFFF, 1'b1, -1, -1);
      for (int i = 0; i < 40; i++) begin
         run4(16'($urandom), 16'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N - 1)) : -1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1);
      end

      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            for (int c = 0; c < 2; c++)
               run1(4'(x), 4'(y), 1'(c));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential operand sequencer for the 4-bit full adder. It adds two 4×NIBBLES-bit unsigned operands by feeding the external 4-bit adder one nibble per clock, least-significant nibble first. Each nibble's carry-out is captured and fed back as the next nibble's carry-in. The block sits directly around the adder: it drives the adder's A/B/cin inputs and consumes its Sum/Cout.

## Interface
- NIBBLES, default 4: number of 4-bit nibbles; operand width W = 4×NIBBLES; legal range 1..8.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  W  operand A; bits [3:0] form nibble 0 (LSB).
- b  input  W  operand B.
- cin  input  1  initial carry-in.
- fa_a  output  4  nibble of A presented to the adder.
- fa_b  output  4  nibble of B presented to the adder.
- fa_cin  output  1  carry presented to the adder.
- fa_sum  input  4  adder sum, combinational from fa_a/fa_b/fa_cin.
- fa_cout  input  1  adder carry-out.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  W  result; held until the next accepted start or reset.
- cout  output  1  final carry-out; held with sum.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: latch a, b and cin into internal registers; clear nibble index to 0; go to RUN.
  - sum and cout keep their previous values.
- RUN, one cycle per nibble i:
  - fa_a = a_reg nibble i, fa_b = b_reg nibble i.
  - fa_cin = latched cin when i=0, otherwise the carry register.
  - At the clock edge, capture fa_sum into sum_reg nibble i and fa_cout into the carry register.
  - If i = NIBBLES−1: go to DONE. Otherwise increment i.
- DONE:
  - sum = sum_reg, cout = carry register, done = 1.
  - Unconditionally return to IDLE on the next edge.
- Outputs in IDLE and DONE: fa_a, fa_b and fa_cin are all 0.
- start while in RUN or DONE is ignored. No queuing; the requester must re-assert start.
- Operands are latched at acceptance. Changing a, b or cin during RUN has no effect.
- Arithmetic is unsigned, modulo 2^W, with cout = bit W of a+b+cin.
- Each intermediate carry is exactly the adder's fa_cout. No carry-lookahead.

## Timing
- Reset (rst=1 at an edge) puts the block in IDLE and forces:
  - busy=0, done=0, sum=0, cout=0;
  - fa_a=0, fa_b=0, fa_cin=0;
  - nibble index=0, carry register=0.
- Reset takes priority over everything, including reset during RUN or DONE. An aborted operation produces no done pulse and its partial sum is discarded.
- Latency: start sampled at edge E0.
  - busy is high for the NIBBLES cycles following E0.
  - done and the final sum/cout appear in the cycle after edge E0+NIBBLES.
  - done drops after edge E0+NIBBLES+1.
- Throughput: one operation per NIBBLES+2 cycles. The next start is accepted at edge E0+NIBBLES+2 at the earliest, i.e. start held high continuously restarts as soon as IDLE is reached.
- The adder path (fa_a/fa_b/fa_cin → fa_sum/fa_cout) must settle within one clock period. The block registers nothing on the adder inputs.
- sum/cout change only at the DONE transition. They stay stable between done pulses.

## Test plan
- Reset, then 0x0000 + 0x0000, cin=0 → done after 4 RUN cycles; sum=0x0000, cout=0; fa_* = 0 outside RUN.
- 0xFFFF + 0x0001, cin=0 → fa_cin=1 in RUN cycles 2..4; sum=0x0000, cout=1.
- 0x1234 + 0x4321, cin=1 → fa_a sequence 4,3,2,1; sum=0x5556, cout=0; done is exactly one cycle, 5 cycles after the start edge.
- Pulse start again during RUN of 0x00FF + 0x0001 → second start ignored; sum=0x0100; no second done.
- Assert rst in RUN cycle 2 of 0xAAAA + 0x5555 → next cycle busy=0, sum=0, cout=0; no done pulse; a new start then completes normally.
- With NIBBLES=1, sweep all A,B ∈ 0..15 (including 15) and cin ∈ {0,1} → {cout,sum} == A+B+cin for all 512 cases; done 2 cycles after each start.
